id_hazard_ctrl: RTL
===================

// Module: id_hazard_ctrl
// PURPOSE
//  Issue controller for the decode stage. Keeps a per-register scoreboard of in-flight writes
//  between ID issue and WB write-back, and stalls ID on true RAW hazards that the WB->ID
//  bypass cannot cover. Flushes IF_ID on taken branches. Sequences interrupts: drains the
//  pipe, then redirects fetch to a fixed vector and records the return PC.
// PARAMETERS
//  NUM_REGS    16            architectural registers; index width = $clog2(NUM_REGS) (4)
//  CNT_W       2             per-register in-flight counter width; max pending = 2**CNT_W-1
//  INT_VECTOR  32'h0000_0100 fetch address driven on interrupt redirect
// PORTS
//  clk           in   1   system clock; all state updates on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  id_valid      in   1   IF_ID holds a real instruction
//  id_rs1        in   4   source reg 1 (instr[27:24])
//  id_rs2        in   4   source reg 2 (instr[23:20])
//  id_use_rs1    in   1   instruction reads rs1
//  id_use_rs2    in   1   instruction reads rs2
//  id_wr_en      in   1   instruction writes a register
//  id_wr_dst     in   4   destination from ID reg-dst mux
//  id_branch     in   1   instruction is a taken branch/jump (branch_pc valid)
//  id_pc_plus_4  in   32  pc_plus_4 of the ID instruction
//  id_interrupt  in   1   interrupt flag carried with the ID instruction
//  wr            in   1   WB register-file write strobe
//  wr_dst        in   4   WB destination
//  stall_id      out  1   hold PC and IF_ID this cycle
//  bubble_ex     out  1   load NOP into ID_EX this cycle
//  flush_if_id   out  1   squash the IF_ID instruction next edge
//  int_redirect  out  1   one-cycle pulse: fetch from int_pc
//  int_pc        out  32  constant INT_VECTOR
//  epc           out  32  saved return PC (registered)
//  busy_mask     out  16  bit r = counter[r] != 0 (debug/visibility)
// BEHAVIOUR
//  - Reset: all counters 0, state IDLE, epc 0; stall_id/bubble_ex/flush_if_id/int_redirect 0.
//  - hazard(src) = use && cnt[src]!=0 && !(wr && wr_dst==src && cnt[src]==1).
//  - Structural stall when id_wr_en && cnt[id_wr_dst]==max and no WB write to it this cycle.
//  - issue = id_valid && state==IDLE && !id_interrupt && !hazard(rs1) && !hazard(rs2) && !struct.
//  - stall_id = id_valid && !issue (combinational); bubble_ex = !issue.
//  - Counter update per reg r, same edge: +1 if issue&&id_wr_en&&id_wr_dst==r; -1 if wr&&wr_dst==r;
//    both -> unchanged. Decrement of zero counter is ignored (never wraps), flagged by assertion.
//  - flush_if_id = issue && id_branch (combinational, 0-cycle); IF redirects to branch_pc.
//  - Interrupt FSM (IDLE, DRAIN, VECTOR):
//    IDLE:   id_valid && id_interrupt -> DRAIN; epc <= id_pc_plus_4 - 4 (instr re-executes).
//    DRAIN:  stall_id=1, bubble_ex=1; when all counters 0 (or will be 0 after this edge) -> VECTOR.
//    VECTOR: int_redirect=1, flush_if_id=1, stall_id=0 for 1 cycle -> IDLE.
//  - Interrupt takes priority over a same-cycle branch in ID (branch not issued, no flush).
//  - Latency: RAW on a reg written in WB this cycle resolves with 0 stall (bypass); worst-case
//    RAW stall = cycles until producer reaches WB.
//  - Reset mid-DRAIN/VECTOR: returns to IDLE, counters cleared, no redirect pulse emitted.
// STRUCTURE
//  - Shared pkg cpu_pkg: REG_IDX_W, NUM_REGS, INT_VECTOR, typedef enum logic[1:0] int_state_t
//    {INT_IDLE, INT_DRAIN, INT_VECTOR}.
//  - One sub-module: reg_scoreboard (counter array + busy_mask + all_clear); FSM/hazard logic top.
// TESTING
//  - Reset mid-traffic: assert rst_n=0 with cnt[3]=2 -> busy_mask=0, state IDLE, outputs 0 async.
//  - RAW: issue wr r2, next instr reads r2 -> stall_id=1 until wr&&wr_dst=2 cycle, issue then.
//  - Same-cycle inc/dec: issue wr r5 while WB writes r5 (cnt=1) -> cnt[5] stays 1, no stall.
//  - Saturation: 3 pending writes to r1, 4th wr r1 -> stall_id=1 until a WB write to r1.
//  - Branch: issue with id_branch=1 -> flush_if_id=1 same cycle, no stall, no bubble.
//  - Interrupt, pc_plus_4=32'h44, 2 writes pending -> DRAIN until clear, 1-cycle int_redirect,
//    int_pc=32'h100, epc=32'h40, back to IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode-stage constants and the interrupt sequencer state type.
package cpu_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int SB_CNT_W  = 2;

  // Fetch address on interrupt redirect. The name carries a _PC suffix so it
  // cannot collide with the INT_VECTOR state literal below.
  localparam logic [31:0] INT_VECTOR_PC = 32'h0000_0100;

  typedef enum logic [1:0] {
    INT_IDLE   = 2'd0,
    INT_DRAIN  = 2'd1,
    INT_VECTOR = 2'd2
  } int_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters between ID issue and WB write-back.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int N_REGS = NUM_REGS,
  parameter int CW     = SB_CNT_W,
  localparam int IW    = $clog2(N_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc_en,
  input  logic [IW-1:0]              inc_idx,
  input  logic                       dec_en,
  input  logic [IW-1:0]              dec_idx,
  output logic [N_REGS-1:0][CW-1:0]  cnt,
  output logic [N_REGS-1:0]          busy_mask,
  output logic                       all_clear,
  output logic                       all_clear_next
);

  logic [N_REGS-1:0] nxt_zero;

  for (genvar r = 0; r < N_REGS; r++) begin : g_reg
    logic          inc, dec, dec_req;
    logic [CW-1:0] cnt_q, cnt_d;

    assign inc     = inc_en && (inc_idx == IW'(r));
    assign dec_req = dec_en && (dec_idx == IW'(r));
    // A write-back to an idle register is dropped so the counter never wraps.
    assign dec     = dec_req && (cnt_q != '0);

    // Next count: simultaneous issue and write-back cancel out.
    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)      cnt_d = cnt_q + CW'(1);
      else if (dec && !inc) cnt_d = cnt_q - CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign cnt[r]       = cnt_q;
    assign busy_mask[r] = (cnt_q != '0);
    assign nxt_zero[r]  = (cnt_d == '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(dec_req && cnt_q == '0));
  end

  assign all_clear      = ~|busy_mask;
  assign all_clear_next = &nxt_zero;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: RAW/structural stalls, branch flush and
// interrupt drain/redirect sequencing.
module id_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int          CNT_W      = SB_CNT_W,
  parameter logic [31:0] INT_VEC_PC = INT_VECTOR_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_wr_en,
  input  logic [3:0]  id_wr_dst,
  input  logic        id_branch,
  input  logic [31:0] id_pc_plus_4,
  input  logic        id_interrupt,
  input  logic        wr,
  input  logic [3:0]  wr_dst,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        int_redirect,
  output logic [31:0] int_pc,
  output logic [31:0] epc,
  output logic [15:0] busy_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic       all_clear, all_clear_next;
  logic       haz_rs1, haz_rs2, struct_stall, issue;
  int_state_t state_q, state_d;

  reg_scoreboard #(.N_REGS(NUM_REGS), .CW(CNT_W)) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc_en         (issue && id_wr_en),
    .inc_idx        (id_wr_dst),
    .dec_en         (wr),
    .dec_idx        (wr_dst),
    .cnt            (cnt),
    .busy_mask      (busy_mask),
    .all_clear      (all_clear),
    .all_clear_next (all_clear_next)
  );

  // A pending write counts as a hazard unless it is the last one and is being
  // written back right now (covered by the WB->ID bypass).
  assign haz_rs1 = id_use_rs1 && (cnt[id_rs1] != '0) &&
                   !(wr && (wr_dst == id_rs1) && (cnt[id_rs1] == CNT_W'(1)));
  assign haz_rs2 = id_use_rs2 && (cnt[id_rs2] != '0) &&
                   !(wr && (wr_dst == id_rs2) && (cnt[id_rs2] == CNT_W'(1)));
  // Saturated counter: only issue if WB frees a slot on the same edge.
  assign struct_stall = id_wr_en && (cnt[id_wr_dst] == CNT_MAX) &&
                        !(wr && (wr_dst == id_wr_dst));

  assign issue = id_valid && (state_q == INT_IDLE) && !id_interrupt &&
                 !haz_rs1 && !haz_rs2 && !struct_stall;

  assign int_pc = INT_VEC_PC;

  // Interrupt sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INT_IDLE;
    else        state_q <= state_d;
  end

  // Interrupt sequencer next state: drain in-flight writes, then redirect once.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INT_IDLE:   if (id_valid && id_interrupt)      state_d = INT_DRAIN;
      INT_DRAIN:  if (all_clear || all_clear_next)   state_d = INT_VECTOR;
      INT_VECTOR:                                     state_d = INT_IDLE;
      default:                                        state_d = INT_IDLE;
    endcase
  end

  // Return PC: the interrupted instruction re-executes after the handler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      epc <= '0;
    else if (state_q == INT_IDLE && id_valid && id_interrupt)
      epc <= id_pc_plus_4 - 32'd4;
  end

  // Pipeline control outputs; held quiet while reset is asserted.
  always_comb begin
    stall_id     = 1'b0;
    bubble_ex    = 1'b0;
    flush_if_id  = 1'b0;
    int_redirect = 1'b0;
    if (rst_n) begin
      bubble_ex = !issue;
      unique case (state_q)
        INT_IDLE: begin
          stall_id    = id_valid && !issue;
          flush_if_id = issue && id_branch;
        end
        INT_DRAIN:  stall_id = 1'b1;
        INT_VECTOR: begin
          int_redirect = 1'b1;
          flush_if_id  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
